// File: rtl/alu_multicycle.sv
// alu_multicycle: iterative multiply/divide unit with valid/ready request and result handshakes.
// Define ALU_MULTICYCLE_FAST_MUL_EN to compute multiplies in one cycle; divides stay iterative.
// Revision: 1.0

`default_nettype none

module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_oper,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_div_by_zero
);

  localparam int CNT_WIDTH = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_MUL   = 3'd0;
  localparam logic [2:0] OP_MULHU = 3'd1;
  localparam logic [2:0] OP_MULHS = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_DIVS  = 3'd4;
  localparam logic [2:0] OP_REMU  = 3'd5;
  localparam logic [2:0] OP_REMS  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIVU) || (op == OP_DIVS) || (op == OP_REMU) || (op == OP_REMS);
  endfunction

  function automatic logic is_rem_op(input logic [2:0] op);
    return (op == OP_REMU) || (op == OP_REMS);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULHS) || (op == OP_DIVS) || (op == OP_REMS);
  endfunction

  // p holds {high, low} of a product, or {remainder, quotient} of a divide.
  function automatic logic [WIDTH-1:0] select_result(input logic [2:0] op,
                                                     input logic [2*WIDTH-1:0] p,
                                                     input logic sa,
                                                     input logic sb);
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   res;
    prod = ((op == OP_MULHS) && (sa ^ sb)) ? -p : p;
    quo  = ((op == OP_DIVS) && (sa ^ sb)) ? -p[WIDTH-1:0] : p[WIDTH-1:0];
    rem  = ((op == OP_REMS) && sa) ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
    res  = '0;
    case (op)
      OP_MUL:             res = prod[WIDTH-1:0];
      OP_MULHU, OP_MULHS: res = prod[2*WIDTH-1:WIDTH];
      OP_DIVU, OP_DIVS:   res = quo;
      OP_REMU, OP_REMS:   res = rem;
      default:            res = '0;
    endcase
    return res;
  endfunction

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]           oper_q, oper_d;
  logic                 sa_q, sa_d;
  logic                 sb_q, sb_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 dbz_q, dbz_d;

  logic                 w_in_signed;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [WIDTH:0]       w_mul_sum;
  logic [WIDTH:0]       w_div_shift;
  logic [WIDTH:0]       w_div_diff;
  logic                 w_div_ge;
  logic [WIDTH-1:0]     w_iter_hi;
  logic [WIDTH-1:0]     w_iter_lo;

  assign w_in_signed = is_signed_op(in_oper);
  assign w_a_neg     = w_in_signed & in_a[WIDTH-1];
  assign w_b_neg     = w_in_signed & in_b[WIDTH-1];
  assign w_a_mag     = w_a_neg ? -in_a : in_a;
  assign w_b_mag     = w_b_neg ? -in_b : in_b;

`ifdef ALU_MULTICYCLE_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_fast_prod;
  assign w_fast_prod = {{WIDTH{1'b0}}, w_a_mag} * {{WIDTH{1'b0}}, w_b_mag};
`endif

  // Multiply: add multiplicand into the high half when the multiplier LSB is set, then shift right.
  assign w_mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  // Restoring divide: shift the next dividend bit into the partial remainder and try to subtract.
  assign w_div_shift = {hi_q, lo_q[WIDTH-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, opnd_q});
  assign w_div_diff  = w_div_shift - {1'b0, opnd_q};

  always_comb begin
    w_iter_hi = w_mul_sum[WIDTH:1];
    w_iter_lo = {w_mul_sum[0], lo_q[WIDTH-1:1]};
    if (is_div_op(oper_q)) begin
      w_iter_hi = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
      w_iter_lo = {lo_q[WIDTH-2:0], w_div_ge};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    oper_d   = oper_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    dbz_d    = dbz_q;

    if (in_flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            oper_d = in_oper;
            sa_d   = w_a_neg;
            sb_d   = w_b_neg;
            cnt_d  = CNT_WIDTH'(WIDTH - 1);
            dbz_d  = 1'b0;
            if (in_oper == OP_RSVD) begin
              result_d = '0;
              state_d  = S_DONE;
            end else if (is_div_op(in_oper) && (in_b == '0)) begin
              result_d = is_rem_op(in_oper) ? in_a : {WIDTH{1'b1}};
              dbz_d    = 1'b1;
              state_d  = S_DONE;
`ifdef ALU_MULTICYCLE_FAST_MUL_EN
            end else if (!is_div_op(in_oper)) begin
              result_d = select_result(in_oper, w_fast_prod, w_a_neg, w_b_neg);
              state_d  = S_DONE;
`endif
            end else begin
              hi_d    = '0;
              lo_d    = is_div_op(in_oper) ? w_a_mag : w_b_mag;
              opnd_d  = is_div_op(in_oper) ? w_b_mag : w_a_mag;
              state_d = S_BUSY;
            end
          end
        end
        S_BUSY: begin
          hi_d  = w_iter_hi;
          lo_d  = w_iter_lo;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            cnt_d    = '0;
            result_d = select_result(oper_q, {w_iter_hi, w_iter_lo}, sa_q, sb_q);
            state_d  = S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      oper_q   <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      oper_q   <= oper_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  assign in_ready        = (state_q == S_IDLE);
  assign out_valid       = (state_q == S_DONE);
  assign out_data        = result_q;
  assign out_div_by_zero = dbz_q & (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed self-checking bench for alu_multicycle at WIDTH=32.
// Revision: 1.0

`default_nettype none

module tb_alu_multicycle;
  localparam int W = 32;
`ifdef ALU_MULTICYCLE_FAST_MUL_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = W;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_oper;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_div_by_zero;

  int checks   = 0;
  int failures = 0;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_oper(in_oper),
    .in_a(in_a), .in_b(in_b), .in_flush(in_flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_div_by_zero(out_div_by_zero)
  );

  always #5 clk = ~clk;

  // lat counts clock edges after the accept edge until out_valid is seen; -1 on timeout.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] data, output logic dbz, output int lat);
    in_oper = op; in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = '0; in_b = '0;
    data = '0; dbz = 1'b0; lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      lat = -1;
    end else begin
      data = out_data; dbz = out_div_by_zero;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_flush = 1'b0; out_ready = 1'b0;
    in_oper = '0; in_a = '0; in_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    checks++; if (out_div_by_zero !== 1'b0) begin failures++; $display("FAIL reset_dbz: got %b expected 0", out_div_by_zero); end
  endtask

  task automatic test_mul();
    logic [W-1:0] d; logic z; int lat;
    run_op(3'd0, 32'h0000_1234, 32'h0000_0010, d, z, lat);
    checks++; if (lat !== MUL_LAT) begin failures++; $display("FAIL mul_latency: got %0d expected %0d", lat, MUL_LAT); end
    checks++; if (d !== 32'h0001_2340) begin failures++; $display("FAIL mul_data: got %h expected 00012340", d); end
    checks++; if (z !== 1'b0) begin failures++; $display("FAIL mul_dbz: got %b expected 0", z); end
    run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, d, z, lat);
    checks++; if (d !== 32'h0000_0001) begin failures++; $display("FAIL mul_max_data: got %h expected 00000001", d); end
  endtask

  task automatic test_mulh();
    logic [W-1:0] d; logic z; int lat;
    run_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, d, z, lat);
    checks++; if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mulhs_data: got %h expected ffffffff", d); end
    run_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, d, z, lat);
    checks++; if (d !== 32'h0000_0001) begin failures++; $display("FAIL mulhu_data: got %h expected 00000001", d); end
    checks++; if (lat !== MUL_LAT) begin failures++; $display("FAIL mulhu_latency: got %0d expected %0d", lat, MUL_LAT); end
    run_op(3'd2, 32'h8000_0000, 32'h8000_0000, d, z, lat);
    checks++; if (d !== 32'h4000_0000) begin failures++; $display("FAIL mulhs_minmin: got %h expected 40000000", d); end
  endtask

  task automatic test_div();
    logic [W-1:0] d; logic z; int lat;
    run_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, d, z, lat);
    checks++; if (d !== 32'hFFFF_FFFD) begin failures++; $display("FAIL divs_data: got %h expected fffffffd", d); end
    checks++; if (lat !== W) begin failures++; $display("FAIL divs_latency: got %0d expected %0d", lat, W); end
    run_op(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, d, z, lat);
    checks++; if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rems_data: got %h expected ffffffff", d); end
    run_op(3'd3, 32'd100, 32'd7, d, z, lat);
    checks++; if (d !== 32'd14) begin failures++; $display("FAIL divu_data: got %h expected 0000000e", d); end
    run_op(3'd5, 32'd100, 32'd7, d, z, lat);
    checks++; if (d !== 32'd2) begin failures++; $display("FAIL remu_data: got %h expected 00000002", d); end
    run_op(3'd7, 32'd100, 32'd7, d, z, lat);
    checks++; if (d !== 32'd0 || lat !== 0) begin failures++; $display("FAIL reserved_op: got data %h lat %0d expected 0 lat 0", d, lat); end
  endtask

  task automatic test_div_by_zero();
    logic [W-1:0] d; logic z; int lat;
    run_op(3'd3, 32'd5, 32'd0, d, z, lat);
    checks++; if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL divu0_data: got %h expected ffffffff", d); end
    checks++; if (z !== 1'b1) begin failures++; $display("FAIL divu0_dbz: got %b expected 1", z); end
    checks++; if (lat !== 0) begin failures++; $display("FAIL divu0_latency: got %0d expected 0", lat); end
    run_op(3'd5, 32'd5, 32'd0, d, z, lat);
    checks++; if (d !== 32'd5) begin failures++; $display("FAIL remu0_data: got %h expected 00000005", d); end
    checks++; if (z !== 1'b1) begin failures++; $display("FAIL remu0_dbz: got %b expected 1", z); end
    run_op(3'd6, 32'hFFFF_FFF9, 32'd0, d, z, lat);
    checks++; if (d !== 32'hFFFF_FFF9) begin failures++; $display("FAIL rems0_data: got %h expected fffffff9", d); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] d; logic z; int lat;
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, d, z, lat);
    checks++; if (d !== 32'h8000_0000) begin failures++; $display("FAIL divs_ovf_data: got %h expected 80000000", d); end
    checks++; if (z !== 1'b0) begin failures++; $display("FAIL divs_ovf_dbz: got %b expected 0", z); end
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, d, z, lat);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL rems_ovf_data: got %h expected 00000000", d); end
  endtask

  task automatic test_backpressure();
    int n;
    in_oper = 3'd3; in_a = 32'd100; in_b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
    checks++; if (!out_valid) begin failures++; $display("FAIL bp_reach_done: got out_valid 0 expected 1"); end
    in_oper = 3'd0; in_a = 32'd3; in_b = 32'd5; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 32'd14) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got valid %b ready %b data %h expected 1 0 0000000e", i, out_valid, in_ready, out_data);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL bp_release: got ready %b valid %b expected 1 0", in_ready, out_valid); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_next_accept: got in_ready %b expected 0", in_ready); end
    n = 0;
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
    checks++; if (out_data !== 32'd15 || out_valid !== 1'b1) begin failures++; $display("FAIL bp_next_data: got %h valid %b expected 0000000f 1", out_data, out_valid); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    logic seen;
    in_oper = 3'd3; in_a = 32'd1000; in_b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 in_flush = 1'b1;
    @(posedge clk); #1;
    in_flush = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL flush_busy: got ready %b valid %b expected 1 0", in_ready, out_valid); end
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL flush_no_result: got out_valid seen %b expected 0", seen); end
    in_oper = 3'd7; in_valid = 1'b1; in_flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_flush = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL flush_wins: got ready %b valid %b expected 1 0", in_ready, out_valid); end
  endtask

  task automatic test_rst_abort();
    logic seen; logic [W-1:0] d; logic z; int lat;
    in_oper = 3'd3; in_a = 32'd12345; in_b = 32'd11; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0) begin failures++; $display("FAIL rst_async: got ready %b valid %b data %h expected 1 0 0", in_ready, out_valid, out_data); end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rst_no_result: got out_valid seen %b expected 0", seen); end
    run_op(3'd3, 32'd100, 32'd7, d, z, lat);
    checks++; if (d !== 32'd14 || lat !== W) begin failures++; $display("FAIL rst_then_divu: got %h lat %0d expected 0000000e lat %0d", d, lat, W); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_div_by_zero();
    test_overflow();
    test_backpressure();
    test_flush();
    test_rst_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
